// File: rtl/ethernet_mmio_arbiter.sv
// Round-robin arbiter sharing the Ethernet control unit MMIO port among requesters.
// Define ETH_MMIO_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins).
module ethernet_mmio_arbiter #(
  parameter int num_req_p    = 2,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int size_width_p = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p-1:0]              req_w_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*size_width_p-1:0] req_size_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              resp_v_o,
  input  logic [num_req_p-1:0]              resp_yumi_i,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic                              resp_err_o,
  output logic [addr_width_p-1:0]           ecu_addr_o,
  output logic                              ecu_write_en_o,
  output logic                              ecu_read_en_o,
  output logic [size_width_p-1:0]           ecu_op_size_o,
  output logic [data_width_p-1:0]           ecu_write_data_o,
  input  logic [data_width_p-1:0]           ecu_read_data_i,
  input  logic                              ecu_decode_err_i
);

  localparam int IdxW = (num_req_p > 2) ? 2 : 1;
  localparam logic [num_req_p-1:0] OneHot0 = {{(num_req_p-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         rr_q, g_q, gnt, rr_d;
  logic                    found;
  logic                    w_q, err_q;
  logic [addr_width_p-1:0] addr_q;
  logic [size_width_p-1:0] size_q;
  logic [data_width_p-1:0] wdata_q, rdata_q;
  logic [num_req_p-1:0]    resp_v_q, gnt_oh, own_oh;
  logic                    issue;

  // Two passes: indices at/after the pointer first, then the wrapped ones.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int j = 0; j < num_req_p; j++) begin
      if (!found && req_v_i[j] && IdxW'(j) >= rr_q) begin
        found = 1'b1;
        gnt   = IdxW'(j);
      end
    end
    for (int j = 0; j < num_req_p; j++) begin
      if (!found && req_v_i[j] && IdxW'(j) < rr_q) begin
        found = 1'b1;
        gnt   = IdxW'(j);
      end
    end
  end

  always_comb begin
    rr_d = '0;
`ifndef ETH_MMIO_ARB_STRICT_PRIO_EN
    if (int'(g_q) != num_req_p - 1) rr_d = g_q + 1'b1;
`endif
  end

  assign gnt_oh = OneHot0 << gnt;
  assign own_oh = OneHot0 << g_q;
  assign issue  = (state_q == ISSUE);

  assign req_ready_o      = (state_q == IDLE && found) ? gnt_oh : '0;
  assign ecu_addr_o       = issue ? addr_q : '0;
  assign ecu_op_size_o    = issue ? size_q : '0;
  assign ecu_write_data_o = issue ? wdata_q : '0;
  assign ecu_write_en_o   = issue & w_q;
  assign ecu_read_en_o    = issue & ~w_q;
  assign resp_v_o         = resp_v_q;
  assign resp_data_o      = rdata_q;
  assign resp_err_o       = err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      g_q      <= '0;
      w_q      <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      resp_v_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            g_q     <= gnt;
            w_q     <= req_w_i[gnt];
            addr_q  <= req_addr_i[int'(gnt)*addr_width_p +: addr_width_p];
            size_q  <= req_size_i[int'(gnt)*size_width_p +: size_width_p];
            wdata_q <= req_data_i[int'(gnt)*data_width_p +: data_width_p];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          err_q   <= ecu_decode_err_i;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          rdata_q  <= (w_q || err_q) ? '0 : ecu_read_data_i;
          resp_v_q <= own_oh;
          state_q  <= RESP;
        end
        RESP: begin
          if (resp_yumi_i[g_q]) begin
            resp_v_q <= '0;
            rr_q     <= rr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Directed bench for ethernet_mmio_arbiter: vector table plus multi-cycle sequences.
module tb_ethernet_mmio_arbiter;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic [1:0]  req_v_i = '0, req_ready_o, req_w_i = '0;
  logic [27:0] req_addr_i = '0;
  logic [3:0]  req_size_i = '0;
  logic [63:0] req_data_i = '0;
  logic [1:0]  resp_v_o, resp_yumi_i = '0;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [13:0] ecu_addr_o;
  logic        ecu_write_en_o, ecu_read_en_o;
  logic [1:0]  ecu_op_size_o;
  logic [31:0] ecu_write_data_o;
  logic [31:0] ecu_read_data_i = '0;
  logic        ecu_decode_err_i = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ethernet_mmio_arbiter dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_data_i(req_data_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .ecu_addr_o(ecu_addr_o), .ecu_write_en_o(ecu_write_en_o),
    .ecu_read_en_o(ecu_read_en_o), .ecu_op_size_o(ecu_op_size_o),
    .ecu_write_data_o(ecu_write_data_o), .ecu_read_data_i(ecu_read_data_i),
    .ecu_decode_err_i(ecu_decode_err_i)
  );

  typedef struct {
    int          r;
    logic        w;
    logic [13:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic w, input logic [13:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    req_w_i[r]            = w;
    req_addr_i[r*14 +: 14] = a;
    req_size_i[r*2 +: 2]   = s;
    req_data_i[r*32 +: 32] = d;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      #1;
      if (resp_v_o != 2'b00) begin
        resp_yumi_i = resp_v_o;
        @(negedge clk);
        resp_yumi_i = '0;
        done = 1'b1;
      end
    end
    chk({name, "_drain"}, {63'd0, done}, 64'd1);
  endtask

  task automatic do_access(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.r;
    @(negedge clk);
    set_req(v.r, v.w, v.addr, v.size, v.data);
    req_v_i = oh;
    #1;
    chk("acc_ready", req_ready_o, oh);
    chk("acc_idle_en", {ecu_write_en_o, ecu_read_en_o}, 2'b00);
    @(negedge clk);
    req_v_i          = '0;
    ecu_decode_err_i = v.err;
    ecu_read_data_i  = 32'hDEAD_BEEF;
    #1;
    chk("acc_issue_en", {ecu_write_en_o, ecu_read_en_o}, v.w ? 2'b10 : 2'b01);
    chk("acc_issue_addr", ecu_addr_o, v.addr);
    chk("acc_issue_size", ecu_op_size_o, v.size);
    chk("acc_issue_wdata", ecu_write_data_o, v.data);
    chk("acc_issue_ready", req_ready_o, 2'b00);
    @(negedge clk);
    ecu_decode_err_i = 1'b0;
    ecu_read_data_i  = v.rdata;
    #1;
    chk("acc_cap_en", {ecu_write_en_o, ecu_read_en_o, ecu_addr_o}, 64'd0);
    chk("acc_cap_respv", resp_v_o, 2'b00);
    @(negedge clk);
    ecu_read_data_i = 32'hCAFE_0000;
    #1;
    chk("acc_resp_v", resp_v_o, oh);
    chk("acc_resp_data", resp_data_o, v.exp_data);
    chk("acc_resp_err", resp_err_o, v.exp_err);
    resp_yumi_i = oh;
    @(negedge clk);
    resp_yumi_i     = '0;
    ecu_read_data_i = '0;
    #1;
    chk("acc_done_v", resp_v_o, 2'b00);
  endtask

  logic [1:0] gr[5];
  int         cyc[5];
  int         ngr;
  logic [1:0] exp_gr[4];

  initial begin
    //          r  w     addr      size  data          rdata         err   exp_data      exp_err
    vecs[0] = '{0, 1'b0, 14'h101C, 2'd2, 32'h0,        32'h1,        1'b0, 32'h1,        1'b0};
    vecs[1] = '{1, 1'b1, 14'h1028, 2'd2, 32'h5EA,      32'h1111,     1'b0, 32'h0,        1'b0};
    vecs[2] = '{0, 1'b0, 14'h1014, 2'd1, 32'h0,        32'h1234,     1'b1, 32'h0,        1'b1};
    vecs[3] = '{1, 1'b0, 14'h3FFC, 2'd3, 32'h0,        32'hFFFF_FFFF,1'b0, 32'hFFFF_FFFF,1'b0};
    vecs[4] = '{0, 1'b1, 14'h0000, 2'd0, 32'hA5A5_A5A5,32'h9999,     1'b1, 32'h0,        1'b1};
    exp_gr  = '{2'b10, 2'b01, 2'b10, 2'b01};

    #1 reset_n_i = 1'b0;
    #1;
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_respv", resp_v_o, 2'b00);
    chk("rst_en", {ecu_write_en_o, ecu_read_en_o}, 2'b00);
    chk("rst_addr_data", {ecu_addr_o, ecu_write_data_o}, 64'd0);
    chk("rst_resp", {resp_err_o, resp_data_o}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;

    for (int i = 0; i < 5; i++) do_access(vecs[i]);

    // Both requesting continuously; last grant was 0 so pointer sits at 1.
    @(negedge clk);
    set_req(0, 1'b0, 14'h0100, 2'd2, 32'h0);
    set_req(1, 1'b0, 14'h0200, 2'd2, 32'h0);
    req_v_i = 2'b11;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      #1;
      if (req_ready_o != 2'b00) begin
        gr[ngr]  = req_ready_o;
        cyc[ngr] = c;
        ngr++;
      end
      resp_yumi_i = resp_v_o;
      @(negedge clk);
    end
    req_v_i     = '0;
    resp_yumi_i = '0;
    drain("rr");
    chk("rr_count", ngr, 4);
    for (int i = 0; i < 4; i++) chk("rr_grant", gr[i], exp_gr[i]);
    for (int i = 1; i < 4; i++) chk("rr_spacing", cyc[i] - cyc[i-1], 4);

    // Response held for 10 cycles while requester 0 keeps a new request pending.
    @(negedge clk);
    set_req(0, 1'b0, 14'h1004, 2'd2, 32'h0);
    req_v_i = 2'b01;
    #1 chk("hold_accept", req_ready_o, 2'b01);
    @(negedge clk);
    @(negedge clk);
    ecu_read_data_i = 32'h0000_0077;
    @(negedge clk);
    ecu_read_data_i = '0;
    resp_yumi_i     = 2'b10;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("hold_stable",
          {resp_v_o, req_ready_o, ecu_write_en_o, ecu_read_en_o, resp_data_o},
          {2'b01, 2'b00, 2'b00, 32'h0000_0077});
      @(negedge clk);
    end
    resp_yumi_i = 2'b01;
    @(negedge clk);
    resp_yumi_i = '0;
    #1 chk("hold_reaccept", req_ready_o, 2'b01);
    @(negedge clk);
    req_v_i = '0;
    #1 chk("hold_reissue", ecu_read_en_o, 1'b1);
    drain("hold");

    // Reset asserted while the access is in CAPTURE.
    @(negedge clk);
    set_req(1, 1'b0, 14'h1010, 2'd2, 32'h0);
    req_v_i = 2'b10;
    @(negedge clk);
    req_v_i = '0;
    @(negedge clk);
    ecu_read_data_i = 32'h55;
    reset_n_i       = 1'b0;
    #1;
    chk("mid_rst_outs",
        {resp_v_o, req_ready_o, ecu_write_en_o, ecu_read_en_o, resp_err_o},
        64'd0);
    chk("mid_rst_data", {ecu_addr_o, resp_data_o}, 64'd0);
    @(negedge clk);
    chk("mid_rst_hold", {resp_v_o, ecu_write_en_o, ecu_read_en_o}, 64'd0);
    reset_n_i       = 1'b1;
    ecu_read_data_i = '0;
    @(negedge clk);
    chk("post_rst_nov", resp_v_o, 2'b00);
    req_v_i = 2'b11;
    #1 chk("post_rst_ptr0", req_ready_o, 2'b01);
    @(negedge clk);
    req_v_i = '0;
    drain("post_rst");
    do_access(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
